// File: rtl/riscv_pkg.sv
// Shared types and constants for the integer pipeline.
package riscv_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_OR  = 4'b0011
    } alu_ctrl_t;

endpackage

// File: rtl/regfile.sv
// Integer register file: 2 read / 1 write, x0 hardwired,
// write-first bypass, synchronous clear.
module regfile
    import riscv_pkg::*;
#(
    parameter int W    = XLEN,
    parameter int NREG = 32,
    localparam int AW  = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] i_ra1,
    input  logic [AW-1:0] i_ra2,
    output logic [W-1:0]  o_rd1,
    output logic [W-1:0]  o_rd2,
    input  logic          i_we,
    input  logic [AW-1:0] i_wa,
    input  logic [W-1:0]  i_wd
);

    logic [W-1:0] r_mem [NREG];
    logic         w_wr;

    assign w_wr = i_we && (i_wa != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr) begin
            r_mem[i_wa] <= i_wd;
        end
    end

    // Write-first: a same-cycle writeback is visible to the reader.
    always_comb begin
        o_rd1 = r_mem[i_ra1];
        o_rd2 = r_mem[i_ra2];
        if (w_wr && (i_wa == i_ra1)) o_rd1 = i_wd;
        if (w_wr && (i_wa == i_ra2)) o_rd2 = i_wd;
        if (i_ra1 == '0) o_rd1 = '0;
        if (i_ra2 == '0) o_rd2 = '0;
    end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute stage: operand fetch, SrcB select and a
// single-entry valid/ready pipeline register with flush.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int W    = XLEN,
    parameter int NREG = 32,
    localparam int AW  = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    input  logic [AW-1:0] rd,
    input  logic [W-1:0]  imm,
    input  logic          alu_src,
    input  logic [3:0]    alu_ctrl_in,
    input  logic          reg_write_in,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [W-1:0]  wb_data,
    output logic          out_valid,
    input  logic          out_ready,
    input  logic          flush,
    output logic [W-1:0]  SrcA,
    output logic [W-1:0]  SrcB,
    output logic [3:0]    ALUctrl,
    output logic [AW-1:0] rd_out,
    output logic          reg_write_out
);

    logic [W-1:0]  w_rd1;
    logic [W-1:0]  w_rd2;
    logic [W-1:0]  w_srcb;
    logic          w_accept;
    logic          w_xfer;

    logic          r_valid;
    logic [W-1:0]  r_srca;
    logic [W-1:0]  r_srcb;
    logic [3:0]    r_ctrl;
    logic [AW-1:0] r_rd;
    logic          r_rw;

    regfile #(
        .W    (W),
        .NREG (NREG)
    ) u_rf (
        .clk   (clk),
        .rst   (rst),
        .i_ra1 (rs1),
        .i_ra2 (rs2),
        .o_rd1 (w_rd1),
        .o_rd2 (w_rd2),
        .i_we  (wb_en),
        .i_wa  (wb_addr),
        .i_wd  (wb_data)
    );

    assign w_srcb   = alu_src ? imm : w_rd2;
    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_xfer   = r_valid && out_ready;

    // Flush only kills valid; payload may go stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_srca  <= '0;
            r_srcb  <= '0;
            r_ctrl  <= '0;
            r_rd    <= '0;
            r_rw    <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_srca  <= w_rd1;
            r_srcb  <= w_srcb;
            r_ctrl  <= alu_ctrl_in;
            r_rd    <= rd;
            r_rw    <= reg_write_in;
        end else if (w_xfer) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid     = r_valid;
    assign SrcA          = r_srca;
    assign SrcB          = r_srcb;
    assign ALUctrl       = r_ctrl;
    assign rd_out        = r_rd;
    assign reg_write_out = r_rw;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        alu_src;
    logic [3:0]  alu_ctrl_in;
    logic        reg_write_in;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic        flush;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [3:0]  ALUctrl;
    logic [4:0]  rd_out;
    logic        reg_write_out;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .rs1           (rs1),
        .rs2           (rs2),
        .rd            (rd),
        .imm           (imm),
        .alu_src       (alu_src),
        .alu_ctrl_in   (alu_ctrl_in),
        .reg_write_in  (reg_write_in),
        .wb_en         (wb_en),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .flush         (flush),
        .SrcA          (SrcA),
        .SrcB          (SrcB),
        .ALUctrl       (ALUctrl),
        .rd_out        (rd_out),
        .reg_write_out (reg_write_out)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; in_valid = 0; rs1 = 0; rs2 = 0; rd = 0;
        imm = 0; alu_src = 0; alu_ctrl_in = 0;
        reg_write_in = 0; wb_en = 0; wb_addr = 0;
        wb_data = 0; out_ready = 1; flush = 0;
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_srca", SrcA, 0);
        chk("rst_srcb", SrcB, 0);
        chk("rst_ctrl", 32'(ALUctrl), 0);
        chk("rst_rd", 32'(rd_out), 0);
        chk("rst_rw", 32'(reg_write_out), 0);
        rst = 0;

        // reset then read
        rs1 = 5; rs2 = 6; rd = 1; in_valid = 1;
        #1 chk("rdy_idle", 32'(in_ready), 1);
        tick();
        in_valid = 0;
        chk("rd0_valid", 32'(out_valid), 1);
        chk("rd0_srca", SrcA, 0);
        chk("rd0_srcb", SrcB, 0);

        // write then read
        wb_en = 1; wb_addr = 3; wb_data = 32'hAA;
        tick();
        chk("xfer_drain", 32'(out_valid), 0);
        wb_en = 0;
        rs1 = 3; alu_src = 1; imm = 32'hFFFF_FFFC;
        alu_ctrl_in = 4'b0001; rd = 9; reg_write_in = 1;
        in_valid = 1;
        tick();
        chk("wr_srca", SrcA, 32'hAA);
        chk("wr_srcb", SrcB, 32'hFFFF_FFFC);
        chk("wr_ctrl", 32'(ALUctrl), 1);
        chk("wr_rd", 32'(rd_out), 9);
        chk("wr_rw", 32'(reg_write_out), 1);

        // same-cycle bypass
        wb_en = 1; wb_addr = 7; wb_data = 32'h1234;
        rs2 = 7; alu_src = 0;
        tick();
        chk("byp_srcb", SrcB, 32'h1234);
        chk("byp_srca", SrcA, 32'hAA);

        // x0 writes ignored, bypass included
        wb_addr = 0; wb_data = 32'hDEAD; rs1 = 0;
        tick();
        chk("x0_byp", SrcA, 0);
        wb_en = 0;
        tick();
        chk("x0_read", SrcA, 0);
        chk("x7_read", SrcB, 32'h1234);

        // stall
        rs1 = 3; rs2 = 7; alu_src = 0; alu_ctrl_in = 4'd2; rd = 4;
        tick();
        out_ready = 0;
        rs1 = 7; alu_src = 1; imm = 32'h55; alu_ctrl_in = 4'd3; rd = 5;
        #1 chk("stall_rdy", 32'(in_ready), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", 32'(out_valid), 1);
            chk("stall_srca", SrcA, 32'hAA);
            chk("stall_srcb", SrcB, 32'h1234);
            chk("stall_ctrl", 32'(ALUctrl), 2);
        end
        out_ready = 1;
        #1 chk("unstall_rdy", 32'(in_ready), 1);
        tick();
        chk("unstall_srca", SrcA, 32'h1234);
        chk("unstall_srcb", SrcB, 32'h55);
        chk("unstall_ctrl", 32'(ALUctrl), 3);
        chk("unstall_rd", 32'(rd_out), 5);

        // back-to-back
        for (int i = 0; i < 4; i++) begin
            rs1 = (i % 2 == 0) ? 5'd3 : 5'd7;
            imm = 32'h100 + 32'(i);
            alu_ctrl_in = 4'(i);
            tick();
            chk("b2b_valid", 32'(out_valid), 1);
            chk("b2b_srca", SrcA, (i % 2 == 0) ? 32'hAA : 32'h1234);
            chk("b2b_srcb", SrcB, 32'h100 + 32'(i));
            chk("b2b_ctrl", 32'(ALUctrl), 32'(i));
        end

        // flush with concurrent writeback
        flush = 1; imm = 32'hBAD;
        wb_en = 1; wb_addr = 10; wb_data = 32'hCAFE;
        tick();
        chk("flush_valid", 32'(out_valid), 0);
        flush = 0; wb_en = 0; in_valid = 0;
        tick();
        chk("flush_gone", 32'(out_valid), 0);
        rs1 = 10; in_valid = 1;
        tick();
        chk("flush_wb_v", 32'(out_valid), 1);
        chk("flush_wb", SrcA, 32'hCAFE);

        // reset mid-operation drops held instr and writeback
        rst = 1; wb_en = 1; wb_addr = 11; wb_data = 32'h77;
        tick();
        chk("mrst_valid", 32'(out_valid), 0);
        chk("mrst_srca", SrcA, 0);
        rst = 0; wb_en = 0;
        rs1 = 3; rs2 = 11; alu_src = 0;
        tick();
        chk("mrst_x3", SrcA, 0);
        chk("mrst_x11", SrcB, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
